// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_unit
//  Purpose  : Execute-stage ALU. Takes the 4-bit aluOp code and two XLEN
//             operands and produces the arithmetic/logic result plus the
//             branch-compare flag. Single-cycle ops finish in one cycle.
//             Shifts run iteratively, SHIFT_STEP bits per cycle.
//  Ports    : clk_i        - clock, rising edge
//             rst_ni       - synchronous active-low reset
//             in_valid_i   / in_ready_o  - issue-side handshake
//             alu_op_i     - {instr[30],funct3}-style op code
//             op_a_i       - operand A (rs1 or PC)
//             op_b_i       - operand B (rs2 or imm), low log2(XLEN) bits = shamt
//             out_valid_o  / out_ready_i - writeback-side handshake
//             result_o     - registered result
//             cmp_out_o    - registered compare outcome
//             illegal_op_o - registered unsupported-op flag (qualified by out_valid_o)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [3:0]      alu_op_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            cmp_out_o,
   output logic            illegal_op_o
);

   localparam int SHAMT_W = $clog2(XLEN);
   localparam logic [SHAMT_W-1:0] C_STEP = SHAMT_W'(SHIFT_STEP);

   // Shift flavour held while iterating
   localparam logic [1:0] C_KIND_SLL = 2'd0;
   localparam logic [1:0] C_KIND_SRL = 2'd1;
   localparam logic [1:0] C_KIND_SRA = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t              state_q,   state_d;
   logic [XLEN-1:0]     result_q,  result_d;
   logic                cmp_q,     cmp_d;
   logic                illegal_q, illegal_d;
   logic [XLEN-1:0]     val_q,     val_d;
   logic [SHAMT_W-1:0]  rem_q,     rem_d;
   logic [1:0]          kind_q,    kind_d;

   logic [XLEN-1:0]     w_res;
   logic                w_cmp;
   logic                w_is_cmp;
   logic                w_ill;
   logic                w_is_shift;
   logic [1:0]          w_kind;
   logic [SHAMT_W-1:0]  w_shamt;
   logic                w_accept;
   logic [SHAMT_W-1:0]  w_step;
   logic [XLEN-1:0]     w_shifted;

   assign w_shamt     = op_b_i[SHAMT_W-1:0];
   // Ready is forced low during reset so nothing is accepted on that edge
   assign in_ready_o  = rst_ni & ((state_q == S_IDLE) |
                                  ((state_q == S_DONE) & out_ready_i));
   assign w_accept    = in_valid_i & in_ready_o;
   assign out_valid_o = (state_q == S_DONE);
   assign result_o    = result_q;
   assign cmp_out_o   = cmp_q;
   assign illegal_op_o = illegal_q;

   // Single-cycle datapath; shifts report op_a here, which is the shamt=0 answer
   always_comb begin
      w_res      = '0;
      w_cmp      = 1'b0;
      w_is_cmp   = 1'b0;
      w_ill      = 1'b0;
      w_is_shift = 1'b0;
      w_kind     = C_KIND_SLL;
      unique case (alu_op_i)
         4'b0000: w_res = op_a_i + op_b_i;
         4'b1000: w_res = op_a_i - op_b_i;
         4'b0100: w_res = op_a_i ^ op_b_i;
         4'b0110: w_res = op_a_i | op_b_i;
         4'b0111: w_res = op_a_i & op_b_i;
         4'b0001: begin w_is_shift = 1'b1; w_kind = C_KIND_SLL; w_res = op_a_i; end
         4'b0101: begin w_is_shift = 1'b1; w_kind = C_KIND_SRL; w_res = op_a_i; end
         4'b1101: begin w_is_shift = 1'b1; w_kind = C_KIND_SRA; w_res = op_a_i; end
         4'b0010: begin w_is_cmp = 1'b1; w_cmp = $signed(op_a_i) <  $signed(op_b_i); end
         4'b0011: begin w_is_cmp = 1'b1; w_cmp = op_a_i < op_b_i; end
         4'b1001: begin w_is_cmp = 1'b1; w_cmp = op_a_i == op_b_i; end
         4'b1010: begin w_is_cmp = 1'b1; w_cmp = op_a_i != op_b_i; end
         4'b1100: begin w_is_cmp = 1'b1; w_cmp = $signed(op_a_i) >= $signed(op_b_i); end
         4'b1011: begin w_is_cmp = 1'b1; w_cmp = op_a_i >= op_b_i; end
         default: w_ill = 1'b1;
      endcase
      if (w_is_cmp) begin
         w_res = {{(XLEN-1){1'b0}}, w_cmp};
      end
   end

   // One iteration of the shifter: move by min(SHIFT_STEP, remaining)
   always_comb begin
      w_step = (rem_q < C_STEP) ? rem_q : C_STEP;
      unique case (kind_q)
         C_KIND_SLL: w_shifted = val_q << w_step;
         C_KIND_SRL: w_shifted = val_q >> w_step;
         default:    w_shifted = $unsigned($signed(val_q) >>> w_step);
      endcase
   end

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      cmp_d     = cmp_q;
      illegal_d = illegal_q;
      val_d     = val_q;
      rem_d     = rem_q;
      kind_d    = kind_q;

      case (state_q)
         S_SHIFT: begin
            val_d = w_shifted;
            rem_d = rem_q - w_step;
            if (rem_q == w_step) begin
               state_d   = S_DONE;
               result_d  = w_shifted;
               cmp_d     = 1'b0;
               illegal_d = 1'b0;
            end
         end
         S_DONE: begin
            if (out_ready_i && !in_valid_i) begin
               state_d = S_IDLE;
            end
         end
         default: ;
      endcase

      // Accept path shared by IDLE and the back-to-back case in DONE
      if (w_accept) begin
         if (w_is_shift && (w_shamt != '0)) begin
            state_d = S_SHIFT;
            val_d   = op_a_i;
            rem_d   = w_shamt;
            kind_d  = w_kind;
         end else begin
            state_d   = S_DONE;
            result_d  = w_res;
            cmp_d     = w_cmp;
            illegal_d = w_ill;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         result_q  <= '0;
         cmp_q     <= 1'b0;
         illegal_q <= 1'b0;
         val_q     <= '0;
         rem_q     <= '0;
         kind_q    <= C_KIND_SLL;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         cmp_q     <= cmp_d;
         illegal_q <= illegal_d;
         val_q     <= val_d;
         rem_q     <= rem_d;
         kind_q    <= kind_d;
      end
   end

endmodule
`default_nettype wire
